insn_fetch_bridge: RTL and testbench

//  Sits between the core's instruction fetch port (insn_fetch_en/addr out, insn_fetch_valid/data/fetched_addr in)
//  and the instruction memory bus (req/gnt request channel, in-order rvalid response channel).

---
 rtl/insn_fetch_bridge_pkg.sv | 15 +
 rtl/fetch_addr_fifo.sv | 53 +++++
 rtl/insn_fetch_bridge.sv | 109 ++++++++++
 tb/tb_insn_fetch_bridge.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/insn_fetch_bridge_pkg.sv
// Shared widths and sizing for the instruction fetch bridge.
// Word addresses drop the two byte-offset bits of ADDR_WIDTH.
package insn_fetch_bridge_pkg;

   localparam int ADDR_WIDTH            = 32;
   localparam int INSN_WIDTH            = 32;
   localparam int FETCH_REQ_DEPTH       = 4;
   localparam int FETCH_MAX_OUTSTANDING = 4;

   // The counter must be able to hold MAX_OUTSTANDING itself, hence the extra bit.
   function automatic int cnt_width(input int max_out);
      return $clog2(max_out) + 1;
   endfunction

endpackage

// File: rtl/fetch_addr_fifo.sv
// Synchronous word-address FIFO. Push and pop may happen in the same cycle, including when full.
// Pointers carry one extra MSB so that full and empty can be told apart.
module fetch_addr_fifo #(
   parameter int WIDTH = 30,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW:0]      wr_q, wr_d;
   logic [PW:0]      rd_q, rd_d;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = mem_q[rd_q[PW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + (PW+1)'(1);
      if (do_pop)  rd_d = rd_q + (PW+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
   end

endmodule

// File: rtl/insn_fetch_bridge.sv
// Bridges the core's fetch port to an in-order req/gnt + rvalid instruction memory bus.
// Requests are queued, issued with a bounded number in flight, and returned with their address.
module insn_fetch_bridge
   import insn_fetch_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH      = insn_fetch_bridge_pkg::ADDR_WIDTH,
   parameter int INSN_WIDTH      = insn_fetch_bridge_pkg::INSN_WIDTH,
   parameter int REQ_DEPTH       = FETCH_REQ_DEPTH,
   parameter int MAX_OUTSTANDING = FETCH_MAX_OUTSTANDING
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  insn_fetch_en,
   input  logic [ADDR_WIDTH-3:0] insn_fetch_addr,
   output logic                  insn_fetch_valid,
   output logic [INSN_WIDTH-1:0] insn_fetch_data,
   output logic [ADDR_WIDTH-3:0] insn_fetched_addr,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-3:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [INSN_WIDTH-1:0] mem_rdata,
   output logic                  ovf_err,
   output logic                  rsp_err
);

   localparam int AW = ADDR_WIDTH - 2;
   localparam int CW = cnt_width(MAX_OUTSTANDING);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   logic          req_full, req_empty, infl_full, infl_empty;
   logic [AW-1:0] req_head, infl_head;
   logic          grant, req_push, rsp_pop;

   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  valid_q, valid_d;
   logic [INSN_WIDTH-1:0] data_q, data_d;
   logic [AW-1:0]         addr_q, addr_d;
   logic                  ovf_q, ovf_d;
   logic                  rsp_q, rsp_d;

   // Issue is driven only by registered state, so req/addr hold steady until granted.
   assign mem_req  = !req_empty && (cnt_q < MAX_CNT) && !infl_full;
   assign mem_addr = mem_req ? req_head : '0;
   assign grant    = mem_req && mem_gnt;
   assign req_push = insn_fetch_en && (!req_full || grant);
   assign rsp_pop  = mem_rvalid && (cnt_q != '0) && !infl_empty;

   fetch_addr_fifo #(.WIDTH(AW), .DEPTH(REQ_DEPTH)) u_req_q (
      .clk     (clk),
      .rst     (rst),
      .push_i  (req_push),
      .data_i  (insn_fetch_addr),
      .pop_i   (grant),
      .full_o  (req_full),
      .empty_o (req_empty),
      .head_o  (req_head)
   );

   fetch_addr_fifo #(.WIDTH(AW), .DEPTH(MAX_OUTSTANDING)) u_infl_q (
      .clk     (clk),
      .rst     (rst),
      .push_i  (grant),
      .data_i  (req_head),
      .pop_i   (rsp_pop),
      .full_o  (infl_full),
      .empty_o (infl_empty),
      .head_o  (infl_head)
   );

   always_comb begin
      cnt_d   = cnt_q + CW'(grant) - CW'(rsp_pop);
      valid_d = rsp_pop;
      data_d  = data_q;
      addr_d  = addr_q;
      if (rsp_pop) begin
         data_d = mem_rdata;
         addr_d = infl_head;
      end
      // Both error flags are sticky until reset.
      ovf_d = ovf_q | (insn_fetch_en && !req_push);
      rsp_d = rsp_q | (mem_rvalid && !rsp_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         ovf_q   <= 1'b0;
         rsp_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         ovf_q   <= ovf_d;
         rsp_q   <= rsp_d;
      end
   end

   assign insn_fetch_valid  = valid_q;
   assign insn_fetch_data   = data_q;
   assign insn_fetched_addr = addr_q;
   assign ovf_err           = ovf_q;
   assign rsp_err           = rsp_q;

endmodule

// File: tb/tb_insn_fetch_bridge.sv
// Directed and random checks of insn_fetch_bridge against a queue-based reference model.
module tb_insn_fetch_bridge;
   import insn_fetch_bridge_pkg::*;

   localparam int AW    = ADDR_WIDTH - 2;
   localparam int IW    = INSN_WIDTH;
   localparam int DEPTH = FETCH_REQ_DEPTH;
   localparam int MAXO  = FETCH_MAX_OUTSTANDING;

   logic          clk = 1'b0;
   logic          rst;
   logic          insn_fetch_en;
   logic [AW-1:0] insn_fetch_addr;
   logic          insn_fetch_valid;
   logic [IW-1:0] insn_fetch_data;
   logic [AW-1:0] insn_fetched_addr;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_gnt;
   logic          mem_rvalid;
   logic [IW-1:0] mem_rdata;
   logic          ovf_err;
   logic          rsp_err;

   insn_fetch_bridge dut (
      .clk               (clk),
      .rst               (rst),
      .insn_fetch_en     (insn_fetch_en),
      .insn_fetch_addr   (insn_fetch_addr),
      .insn_fetch_valid  (insn_fetch_valid),
      .insn_fetch_data   (insn_fetch_data),
      .insn_fetched_addr (insn_fetched_addr),
      .mem_req           (mem_req),
      .mem_addr          (mem_addr),
      .mem_gnt           (mem_gnt),
      .mem_rvalid        (mem_rvalid),
      .mem_rdata         (mem_rdata),
      .ovf_err           (ovf_err),
      .rsp_err           (rsp_err)
   );

   always #5 clk = ~clk;

   // Reference model: queued and in-flight addresses plus expected registered outputs.
   logic [AW-1:0] m_req [$];
   logic [AW-1:0] m_fly [$];
   logic          m_valid = 1'b0;
   logic [IW-1:0] m_data  = '0;
   logic [AW-1:0] m_addr  = '0;
   logic          m_ovf   = 1'b0;
   logic          m_rsp   = 1'b0;
   logic [1:0]    gh      = '0;

   int n_cmp = 0;
   int n_err = 0;
   int n_gnt = 0;
   int n_vld = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic en, input logic [AW-1:0] a, input logic g,
                       input logic rv, input logic [IW-1:0] rd, input logic r);
      logic exp_req;
      logic gr;
      int   rs;
      int   fs;
      insn_fetch_en   = en;
      insn_fetch_addr = a;
      mem_gnt         = g;
      mem_rvalid      = rv;
      mem_rdata       = rd;
      rst             = r;
      #1;
      rs      = m_req.size();
      fs      = m_fly.size();
      exp_req = (rs > 0) && (fs < MAXO);
      chk("mem_req", mem_req, exp_req);
      if (exp_req) chk("mem_addr", mem_addr, m_req[0]);
      if (mem_req && g) n_gnt++;
      @(posedge clk);
      if (r) begin
         m_req.delete();
         m_fly.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_addr  = '0;
         m_ovf   = 1'b0;
         m_rsp   = 1'b0;
         gh      = '0;
      end else begin
         gr      = exp_req && g;
         m_valid = 1'b0;
         if (rv) begin
            if (fs > 0) begin
               m_addr  = m_fly.pop_front();
               m_data  = rd;
               m_valid = 1'b1;
            end else begin
               m_rsp = 1'b1;
            end
         end
         if (gr) m_fly.push_back(m_req.pop_front());
         if (en) begin
            if (rs < DEPTH || gr) m_req.push_back(a);
            else m_ovf = 1'b1;
         end
         gh = {gh[0], gr};
      end
      #1;
      chk("fetch_valid", insn_fetch_valid, m_valid);
      chk("fetch_data", insn_fetch_data, m_data);
      chk("fetched_addr", insn_fetched_addr, m_addr);
      chk("ovf_err", ovf_err, m_ovf);
      chk("rsp_err", rsp_err, m_rsp);
      if (insn_fetch_valid) n_vld++;
   endtask

   task automatic idle(input logic g);
      step(1'b0, '0, g, 1'b0, '0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && (m_req.size() > 0 || m_fly.size() > 0); i++)
         step(1'b0, '0, 1'b1, m_fly.size() > 0, $urandom, 1'b0);
      chk("drain_idle_req", mem_req, 1'b0);
   endtask

   initial begin
      rst = 1'b1; insn_fetch_en = 1'b0; insn_fetch_addr = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", insn_fetch_valid, 1'b0);
      chk("rst_data", insn_fetch_data, 0);
      chk("rst_addr", insn_fetched_addr, 0);
      chk("rst_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_ovf", ovf_err, 1'b0);
      chk("rst_rsp", rsp_err, 1'b0);

      // Single fetch, rvalid three cycles after the grant.
      step(1'b1, AW'(32'h100), 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
      chk("t1_valid", insn_fetch_valid, 1'b1);
      chk("t1_data", insn_fetch_data, 32'hDEADBEEF);
      chk("t1_addr", insn_fetched_addr, 32'h100);
      idle(1'b0);

      // Streaming with a fixed two-cycle memory latency.
      n_vld = 0;
      for (int k = 0; k < 14; k++)
         step(k < 8, AW'(32'h10 + k), 1'b1, gh[1], $urandom, 1'b0);
      chk("t2_pulses", n_vld, 8);
      chk("t2_last_addr", insn_fetched_addr, 32'h17);

      // Outstanding limit with responses withheld.
      n_gnt = 0;
      for (int k = 0; k < 8; k++)
         step(k < 6, AW'(32'h20 + k), 1'b1, 1'b0, '0, 1'b0);
      chk("t3_grants", n_gnt, 4);
      chk("t3_req_blocked", mem_req, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, $urandom, 1'b0);
      chk("t3_req_reopen", mem_req, 1'b1);
      drain();

      // Overflow: fifth request into a full queue is dropped.
      n_vld = 0;
      for (int k = 0; k < 5; k++)
         step(1'b1, AW'(32'h30 + k), 1'b0, 1'b0, '0, 1'b0);
      chk("t4_ovf", ovf_err, 1'b1);
      idle(1'b0);
      chk("t4_ovf_sticky", ovf_err, 1'b1);
      drain();
      chk("t4_pulses", n_vld, 4);
      chk("t4_last_addr", insn_fetched_addr, 32'h33);

      // Full queue with a same-cycle grant accepts the new request.
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      n_vld = 0;
      for (int k = 0; k < 4; k++)
         step(1'b1, AW'(32'h40 + k), 1'b0, 1'b0, '0, 1'b0);
      step(1'b1, AW'(32'h44), 1'b1, 1'b0, '0, 1'b0);
      chk("t5_no_ovf", ovf_err, 1'b0);
      drain();
      chk("t5_pulses", n_vld, 5);
      chk("t5_last_addr", insn_fetched_addr, 32'h44);

      // Reset with two in flight and two queued, then a late response.
      for (int k = 0; k < 4; k++)
         step(1'b1, AW'(32'h50 + k), 1'b0, 1'b0, '0, 1'b0);
      idle(1'b1);
      idle(1'b1);
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      chk("t6_valid", insn_fetch_valid, 1'b0);
      chk("t6_data", insn_fetch_data, 0);
      chk("t6_addr", insn_fetched_addr, 0);
      chk("t6_req", mem_req, 1'b0);
      chk("t6_mem_addr", mem_addr, 0);
      chk("t6_ovf", ovf_err, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1, 32'h12345678, 1'b0);
      chk("t6_late_valid", insn_fetch_valid, 1'b0);
      chk("t6_late_rsp", rsp_err, 1'b1);

      // Random traffic against the model.
      step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
      for (int k = 0; k < 300; k++)
         step(1'($urandom_range(0, 1)), AW'($urandom), 1'($urandom_range(0, 1)),
              (m_fly.size() > 0) && ($urandom_range(0, 2) != 0), $urandom, 1'b0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
